// File: rtl/serial_word_tx_pkg.sv
// ============================================================================
// serial_word_tx_pkg
// Line-level constants and FSM state encoding shared by the serial transmitter
// and its matching receiver.
// Revision: 1.0
// ============================================================================
`default_nettype none

package serial_word_tx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    localparam logic TX_IDLE_LEVEL  = 1'b1;
    localparam logic TX_START_LEVEL = 1'b0;

endpackage

`default_nettype wire

// File: rtl/serial_word_tx_bit_timer.sv
// ============================================================================
// bit_timer
// Per-bit cycle counter: counts 0..CLKS_PER_BIT-1 and flags the terminal cycle.
// Revision: 1.0
// ============================================================================
`default_nettype none

module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick,
    output logic tick_next
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] c_LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign tick = (cnt_q == c_LAST);

    // tick_next lets the owner register a flag that lines up with the terminal cycle.
    generate
        if (CLKS_PER_BIT == 1) begin : g_single
            assign tick_next = 1'b1;
        end else begin : g_multi
            localparam logic [CW-1:0] c_PRE = CW'(CLKS_PER_BIT - 2);
            assign tick_next = (cnt_q == c_PRE);
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/serial_word_tx.sv
// ============================================================================
// serial_word_tx
// Valid/ready parallel-in, LSB-first serial-out transmitter with start/stop framing.
// Revision: 1.0
// ============================================================================
`default_nettype none

module serial_word_tx
    import serial_word_tx_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              done
);

    localparam int BW = $clog2(DATA_W + 1);
    localparam logic [BW-1:0] c_LAST_BIT = BW'(DATA_W - 1);

    state_e            state_q;
    logic [DATA_W-1:0] shreg_q;
    logic [BW-1:0]     bit_cnt_q;
    logic              tx_q;
    logic              busy_q;
    logic              done_q;

    logic              w_tick;
    logic              w_tick_next;
    logic [DATA_W-1:0] w_shifted;

    // Timer is held at zero while idle, so every frame starts on a fresh bit period.
    bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_bit_timer (
        .clk       (clk),
        .reset     (reset),
        .clear     (state_q == IDLE),
        .tick      (w_tick),
        .tick_next (w_tick_next)
    );

    assign w_shifted = shreg_q >> 1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            tx_q      <= TX_IDLE_LEVEL;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (in_valid) begin
                        shreg_q   <= in;
                        bit_cnt_q <= '0;
                        tx_q      <= TX_START_LEVEL;
                        busy_q    <= 1'b1;
                        state_q   <= START;
                    end
                end
                START: begin
                    if (w_tick) begin
                        tx_q    <= shreg_q[0];
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        shreg_q <= w_shifted;
                        if (bit_cnt_q == c_LAST_BIT) begin
                            bit_cnt_q <= '0;
                            tx_q      <= TX_IDLE_LEVEL;
                            done_q    <= (CLKS_PER_BIT == 1);
                            state_q   <= STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                            tx_q      <= w_shifted[0];
                        end
                    end
                end
                STOP: begin
                    if (w_tick) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        done_q <= w_tick_next;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready = (state_q == IDLE);
    assign tx       = tx_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

`default_nettype wire
